ram_march_bist: RTL
===================

// Module: ram_march_bist
// PURPOSE
//  Initiator for the single-port ram block (we/re/addr/in/out): drives its ports to run a
//  March C- style self-test (write bg, read-verify/invert ascending, read-verify/invert
//  descending, final read) and reports pass, or the first failing address/data/phase.
//  Sits between the ram instance and system control; the RAM is owned by the BIST while busy.
// PARAMETERS
//  DATA_WIDTH  7  RAM word width
//  ADDR_WIDTH  5  RAM address width; depth N = 2**ADDR_WIDTH
//  RD_LAT      1  cycles from ram_re sample edge to ram_out valid (>=1)
// PORTS
//  clk         in   1   clock, all logic on rising edge
//  rst         in   1   asynchronous, active-low reset
//  start       in   1   1-cycle pulse: begin test (ignored while busy)
//  abort       in   1   synchronous: stop test, return to idle
//  busy        out  1   test in progress
//  done        out  1   test finished (level, held until next start/abort/reset)
//  pass        out  1   valid when done: 1 = no mismatch
//  fail_addr   out  ADDR_WIDTH  first failing address (valid when done & !pass)
//  fail_data   out  DATA_WIDTH  ram_out value read at failure
//  fail_phase  out  2   phase (0..3) in which failure occurred
//  ram_we      out  1   to ram.we
//  ram_re      out  1   to ram.re
//  ram_addr    out  ADDR_WIDTH  to ram.addr
//  ram_in      out  DATA_WIDTH  to ram.in
//  ram_out     in   DATA_WIDTH  from ram.out
// BEHAVIOUR
//  Reset (async, rst=0): all outputs 0, FSM IDLE, addr/phase counters 0. ram_we/ram_re drop
//   immediately; a reset mid-test abandons it with no done pulse.
//  Phases (bg = all zeros, inv = all ones):
//   P0 up:   W bg          P1 up:   R bg, W inv
//   P2 down: R inv, W bg   P3 up:   R bg
//  FSM: IDLE -> WR (P0) ; RD -> WAIT -> [WR] ; DONE.
//   IDLE: start=1 -> busy=1, done=0, pass=0, phase=0, addr=0, go WR.
//   WR: 1 cycle, ram_we=1, ram_re=0, ram_in=phase write value; then next addr.
//   RD: 1 cycle, ram_re=1, ram_we=0; then WAIT.
//   WAIT: RD_LAT cycles, ram_we=ram_re=0; ram_out compared to expected on last cycle.
//    mismatch -> capture fail_addr/fail_data/fail_phase, go DONE with pass=0;
//    match -> WR (P1,P2) or next addr (P3).
//   Next addr: up phases 0..N-1, down phase N-1..0; at last addr advance phase and load its
//    start addr (P2 starts at N-1); after P3 last addr -> DONE with pass=1.
//   DONE: busy=0, done=1; start re-runs from P0 (fail_* cleared on start).
//  ram_addr held stable from RD through WAIT/WR of the same element; never we&re together.
//  Cycles/element: write-only 1, read-write RD_LAT+2, read-only RD_LAT+1.
//   Pass run: N + 2N(RD_LAT+2) + N(RD_LAT+1) cycles busy (288 for N=32, RD_LAT=1).
//  abort=1 (any state except IDLE): next cycle IDLE, busy=0, done=0, pass=0; abort beats start.
//  Address counter is ADDR_WIDTH wide; terminal compare, not wrap, ends each phase.
// STRUCTURE
//  Shared package ram_bist_pkg: state encoding (IDLE,WR,RD,WAIT,DONE), phase table constants
//   (direction, read-expect sel, write sel, has_read, has_write per phase), bg/inv select codes.
//  One natural sub-module: ram_bist_addr_gen (up/down counter, load start, last flag).
//  Bench instantiates ram with DATA_WIDTH=7, ADDR_WIDTH=5 plus a fault-injection wrapper.
// TESTING
//  1 Fault-free RAM, start pulse -> busy 288 cycles, done=1, pass=1, fail_*=0.
//  2 Bit2 of addr 5 stuck-at-0 -> done, pass=0, fail_phase=2, fail_addr=5, fail_data=7'h7B.
//  3 Addr 31 bit0 stuck-at-1 -> fail_phase=1, fail_addr=31, fail_data=7'h01.
//  4 rst=0 at cycle 100 of run -> ram_we/ram_re/busy 0 same cycle; after release, idle, done=0.
//  5 abort at cycle 50, start pulse while busy ignored -> idle next cycle; fresh start gives pass.
//  6 Protocol monitor all runs: never ram_we&ram_re; ram_addr stable RD->WR; P2 addresses descend.

Source files
------------

// File: rtl/ram_march_bist_pkg.sv
// Shared definitions for the March C- RAM self-test.
// FSM state encoding, pattern select codes and the per-phase table:
// direction, read-expect pattern, write pattern, has_read, has_write.
package ram_bist_pkg;

  typedef enum logic [2:0] {S_IDLE, S_WR, S_RD, S_WAIT, S_DONE} state_t;

  // bg = all zeros, inv = all ones
  typedef enum logic {SEL_BG = 1'b0, SEL_INV = 1'b1} pat_sel_t;

  typedef struct packed {
    logic     down;
    logic     has_read;
    logic     has_write;
    pat_sel_t rd_sel;
    pat_sel_t wr_sel;
  } phase_cfg_t;

  // P0 up W bg | P1 up R bg,W inv | P2 down R inv,W bg | P3 up R bg
  function automatic phase_cfg_t phase_cfg(input logic [1:0] p);
    phase_cfg_t c;
    case (p)
      2'd0:    c = '{down: 1'b0, has_read: 1'b0, has_write: 1'b1, rd_sel: SEL_BG,  wr_sel: SEL_BG};
      2'd1:    c = '{down: 1'b0, has_read: 1'b1, has_write: 1'b1, rd_sel: SEL_BG,  wr_sel: SEL_INV};
      2'd2:    c = '{down: 1'b1, has_read: 1'b1, has_write: 1'b1, rd_sel: SEL_INV, wr_sel: SEL_BG};
      default: c = '{down: 1'b0, has_read: 1'b1, has_write: 1'b0, rd_sel: SEL_BG,  wr_sel: SEL_BG};
    endcase
    return c;
  endfunction

  function automatic logic phase_down(input logic [1:0] p);
    phase_cfg_t c;
    c = phase_cfg(p);
    return c.down;
  endfunction

  function automatic logic phase_reads(input logic [1:0] p);
    phase_cfg_t c;
    c = phase_cfg(p);
    return c.has_read;
  endfunction

endpackage

// File: rtl/ram_march_bist_if.sv
// Single-port RAM bus: we/re/addr/din driven by the initiator, dout from the RAM.
//  master: BIST side   slave: RAM side
interface ram_march_bist_if #(
  parameter int DATA_WIDTH = 7,
  parameter int ADDR_WIDTH = 5
);
  logic                  we;
  logic                  re;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] din;
  logic [DATA_WIDTH-1:0] dout;

  modport master (output we, re, addr, din, input dout);
  modport slave  (input we, re, addr, din, output dout);
endinterface

// File: rtl/ram_bist_addr_gen.sv
// Up/down address counter for the march elements.
//  load/load_down : load start address (0 or N-1) for a new phase
//  step/down      : advance one address in the current phase direction
//  addr/last      : current address, terminal address of the phase
module ram_bist_addr_gen #(
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  load_down,
  input  logic                  step,
  input  logic                  down,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  last
);
  localparam logic [ADDR_WIDTH-1:0] TOP = '1;
  localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      addr <= '0;
    else if (load) addr <= load_down ? TOP : '0;
    else if (step) addr <= down ? addr - ONE : addr + ONE;
  end

  // phase ends on a terminal compare; the counter never relies on wrap
  assign last = down ? (addr == '0) : (addr == TOP);
endmodule

// File: rtl/ram_march_bist.sv
// March C- self-test initiator for a single-port RAM.
//  clk, rst (async, active low)
//  start : pulse, begin test (ignored while busy)   abort : return to idle
//  busy/done/pass, fail_addr/fail_data/fail_phase : status and first failure
//  ram   : RAM bus (master side)
module ram_march_bist
  import ram_bist_pkg::*;
#(
  parameter int DATA_WIDTH = 7,
  parameter int ADDR_WIDTH = 5,
  parameter int RD_LAT     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [DATA_WIDTH-1:0] fail_data,
  output logic [1:0]            fail_phase,
  ram_march_bist_if.master      ram
);
  localparam int WCW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  state_t                state_q, state_d;
  logic [1:0]            phase_q, phase_nxt;
  logic [WCW-1:0]        wcnt_q;
  phase_cfg_t            cfg;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  last, wait_last;
  logic [DATA_WIDTH-1:0] exp_rd, wr_val;
  logic                  elem_end, run_start, clr, phase_inc, set_pass, capture;
  logic                  ag_load, ag_load_down, ag_step;

  assign cfg       = phase_cfg(phase_q);
  assign phase_nxt = phase_q + 2'd1;
  assign exp_rd    = {DATA_WIDTH{cfg.rd_sel == SEL_INV}};
  assign wr_val    = {DATA_WIDTH{cfg.wr_sel == SEL_INV}};
  assign wait_last = (wcnt_q == WCW'(RD_LAT - 1));

  ram_bist_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_addr (
    .clk       (clk),
    .rst       (rst),
    .load      (ag_load),
    .load_down (ag_load_down),
    .step      (ag_step),
    .down      (cfg.down),
    .addr      (addr),
    .last      (last)
  );

  always_comb begin
    state_d      = state_q;
    elem_end     = 1'b0;
    run_start    = 1'b0;
    clr          = 1'b0;
    phase_inc    = 1'b0;
    set_pass     = 1'b0;
    capture      = 1'b0;
    ag_load      = 1'b0;
    ag_load_down = 1'b0;
    ag_step      = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: if (start) begin
        state_d   = S_WR;
        run_start = 1'b1;
        ag_load   = 1'b1;
      end
      S_WR:   elem_end = 1'b1;
      S_RD:   state_d  = S_WAIT;
      S_WAIT: if (wait_last) begin
        if (ram.dout != exp_rd) begin
          state_d = S_DONE;
          capture = 1'b1;
        end else if (cfg.has_write) state_d = S_WR;
        else                        elem_end = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    // element finished: next address, next phase, or end of test
    if (elem_end) begin
      if (!last) begin
        ag_step = 1'b1;
        state_d = cfg.has_read ? S_RD : S_WR;
      end else if (phase_q == 2'd3) begin
        state_d  = S_DONE;
        set_pass = 1'b1;
      end else begin
        phase_inc    = 1'b1;
        ag_load      = 1'b1;
        ag_load_down = phase_down(phase_nxt);
        state_d      = phase_reads(phase_nxt) ? S_RD : S_WR;
      end
    end

    // abort overrides everything, including a coincident start
    if (abort && state_q != S_IDLE) begin
      state_d      = S_IDLE;
      clr          = 1'b1;
      run_start    = 1'b0;
      phase_inc    = 1'b0;
      set_pass     = 1'b0;
      capture      = 1'b0;
      ag_step      = 1'b0;
      ag_load      = 1'b1;
      ag_load_down = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      phase_q    <= '0;
      wcnt_q     <= '0;
      pass       <= 1'b0;
      fail_addr  <= '0;
      fail_data  <= '0;
      fail_phase <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= (state_q == S_WAIT) ? wcnt_q + WCW'(1) : '0;
      if (run_start || clr)  phase_q <= '0;
      else if (phase_inc)    phase_q <= phase_nxt;
      if (run_start || clr) begin
        pass       <= 1'b0;
        fail_addr  <= '0;
        fail_data  <= '0;
        fail_phase <= '0;
      end else begin
        if (set_pass) pass <= 1'b1;
        if (capture) begin
          fail_addr  <= addr;
          fail_data  <= ram.dout;
          fail_phase <= phase_q;
        end
      end
    end
  end

  // decoded straight from state so reset drops them without waiting for a clock
  assign busy     = (state_q == S_WR) || (state_q == S_RD) || (state_q == S_WAIT);
  assign done     = (state_q == S_DONE);
  assign ram.we   = (state_q == S_WR);
  assign ram.re   = (state_q == S_RD);
  assign ram.addr = addr;
  assign ram.din  = (state_q == S_WR) ? wr_val : '0;
endmodule
